// File: rtl/bcd_timer_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : stopwatch_pkg                                                |
// | Description : Shared types and constants for the mm:ss BCD timer.          |
// |               State encoding of the timer FSM and the BCD digit constants  |
// |               used by the field counters.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] c_BCD_NINE = 4'd9;
    localparam logic [3:0] c_BCD_FIVE = 4'd5;
    localparam logic [3:0] c_BCD_ZERO = 4'd0;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_timer_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : bcd_timer_core_if                                            |
// | Description : Control inputs and display outputs of bcd_timer_core.        |
// |   master : drives ticks/levels, observes digits and flags                  |
// |   slave  : the timer core                                                  |
// |   tick_1hz, tick_2hz        single-cycle count / adjust enables            |
// |   button_pause, switch_adj, switch_sel, mode_down   debounced levels       |
// |   button_lap                only when LAP_HOLD_EN is defined               |
// |   bcd_*                     four BCD digits mm:ss                          |
// |   is_adj, is_sel_sec, done, running   status flags                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bcd_timer_core_if;

    logic       tick_1hz;
    logic       tick_2hz;
    logic       button_pause;
    logic       switch_adj;
    logic       switch_sel;
    logic       mode_down;
`ifdef LAP_HOLD_EN
    logic       button_lap;
`endif
    logic [3:0] bcd_min_tens;
    logic [3:0] bcd_min_ones;
    logic [3:0] bcd_sec_tens;
    logic [3:0] bcd_sec_ones;
    logic       is_adj;
    logic       is_sel_sec;
    logic       done;
    logic       running;

    modport master (
        output tick_1hz, tick_2hz, button_pause, switch_adj, switch_sel, mode_down,
`ifdef LAP_HOLD_EN
        output button_lap,
`endif
        input  bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones,
        input  is_adj, is_sel_sec, done, running
    );

    modport slave (
        input  tick_1hz, tick_2hz, button_pause, switch_adj, switch_sel, mode_down,
`ifdef LAP_HOLD_EN
        input  button_lap,
`endif
        output bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones,
        output is_adj, is_sel_sec, done, running
    );

endinterface : bcd_timer_core_if
`default_nettype wire

// File: rtl/bcd_field_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_field_counter                                            |
// | Description : Two-digit BCD up/down counter with programmable upper limit. |
// |   inc/dec      step by one (inc wins if both asserted)                     |
// |   carry_en     allows wrap_out to report a wrap to the next field          |
// |   limit_*      highest value of the field, wraps limit <-> 00              |
// |   tens/ones    registered digits                                           |
// |   wrap_out     combinational: this step wraps (qualified by carry_en)      |
// |   is_zero      field currently reads 00                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_field_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       carry_en,
    input  logic [3:0] limit_tens,
    input  logic [3:0] limit_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap_out,
    output logic       is_zero
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_limit;

    assign w_at_limit = (r_tens == limit_tens) && (r_ones == limit_ones);
    assign is_zero    = (r_tens == c_BCD_ZERO) && (r_ones == c_BCD_ZERO);
    assign wrap_out   = carry_en && ((inc && w_at_limit) || (dec && is_zero));
    assign tens       = r_tens;
    assign ones       = r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= c_BCD_ZERO;
            r_ones <= c_BCD_ZERO;
        end else if (inc) begin
            if (w_at_limit) begin
                r_tens <= c_BCD_ZERO;
                r_ones <= c_BCD_ZERO;
            end else if (r_ones == c_BCD_NINE) begin
                r_ones <= c_BCD_ZERO;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end else if (dec) begin
            if (is_zero) begin
                r_tens <= limit_tens;
                r_ones <= limit_ones;
            end else if (r_ones == c_BCD_ZERO) begin
                r_ones <= c_BCD_NINE;
                r_tens <= r_tens - 4'd1;
            end else begin
                r_ones <= r_ones - 4'd1;
            end
        end
    end

endmodule : bcd_field_counter
`default_nettype wire

// File: rtl/bcd_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_timer_core                                               |
// | Description : mm:ss BCD timer with count-up/count-down, minute limit,      |
// |               expiry flag and field adjust mode.                           |
// |   clk_100mhz   system clock, rising edge                                   |
// |   rst_n        asynchronous active-low reset                               |
// |   bus          bcd_timer_core_if.slave: ticks, debounced levels in;        |
// |                BCD digits and is_adj/is_sel_sec/done/running out           |
// |   MAX_MIN      highest minute value (1..99)                                |
// |   START_RUNNING  1 = RUN after reset, 0 = PAUSED after reset               |
// |   Macro LAP_HOLD_EN: adds button_lap and a lap snapshot of the digits.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_timer_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN       = 99,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    bcd_timer_core_if.slave         bus
);

    localparam logic [3:0] c_MIN_TENS    = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_MIN_ONES    = 4'(MAX_MIN % 10);
    localparam state_t     c_RESET_STATE = START_RUNNING ? ST_RUN : ST_PAUSED;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_pause_q;
    logic       r_running;
    logic       r_done;
    logic       r_is_adj;
    logic       r_is_sel_sec;

    logic       w_pause_edge;
    logic       w_run_step;
    logic       w_adj_step;
    logic       w_time_zero;
    logic       w_next_zero;

    logic [3:0] w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
    logic       w_sec_inc, w_sec_dec, w_sec_wrap, w_sec_zero;
    logic       w_min_inc, w_min_dec, w_min_zero;
    // Minutes are the top field: their wrap has nowhere to go.
    logic       w_min_wrap_unused;

    assign w_pause_edge = bus.button_pause && !r_pause_q;

    // switch_adj overrides every other event, so it also masks stepping.
    assign w_run_step = (r_state == ST_RUN)    && !bus.switch_adj && bus.tick_1hz;
    assign w_adj_step = (r_state == ST_ADJUST) &&  bus.switch_adj && bus.tick_2hz;

    assign w_time_zero = w_min_zero && w_sec_zero;
    assign w_next_zero = w_min_zero && (w_sec_tens == c_BCD_ZERO) && (w_sec_ones == 4'd1);

    // A down tick at 00:00 must not decrement (would wrap to MAX_MIN:59).
    assign w_sec_inc = (w_run_step && !bus.mode_down) || (w_adj_step && bus.switch_sel);
    assign w_sec_dec = w_run_step && bus.mode_down && !w_time_zero;
    assign w_min_inc = (w_sec_wrap && !bus.mode_down) || (w_adj_step && !bus.switch_sel);
    assign w_min_dec = w_sec_wrap && bus.mode_down;

    bcd_field_counter u_sec (
        .clk        (clk_100mhz),
        .rst_n      (rst_n),
        .inc        (w_sec_inc),
        .dec        (w_sec_dec),
        .carry_en   (w_run_step),
        .limit_tens (c_BCD_FIVE),
        .limit_ones (c_BCD_NINE),
        .tens       (w_sec_tens),
        .ones       (w_sec_ones),
        .wrap_out   (w_sec_wrap),
        .is_zero    (w_sec_zero)
    );

    bcd_field_counter u_min (
        .clk        (clk_100mhz),
        .rst_n      (rst_n),
        .inc        (w_min_inc),
        .dec        (w_min_dec),
        .carry_en   (1'b0),
        .limit_tens (c_MIN_TENS),
        .limit_ones (c_MIN_ONES),
        .tens       (w_min_tens),
        .ones       (w_min_ones),
        .wrap_out   (w_min_wrap_unused),
        .is_zero    (w_min_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bus.switch_adj) begin
            w_state_nxt = ST_ADJUST;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Pause wins over expiry; the step itself is still applied.
                    if (w_pause_edge)
                        w_state_nxt = ST_PAUSED;
                    else if (bus.tick_1hz && bus.mode_down && (w_time_zero || w_next_zero))
                        w_state_nxt = ST_EXPIRED;
                end
                ST_PAUSED: begin
                    if (w_pause_edge && !(bus.mode_down && w_time_zero))
                        w_state_nxt = ST_RUN;
                end
                ST_ADJUST:  w_state_nxt = ST_PAUSED;
                ST_EXPIRED: begin
                    if (w_pause_edge)
                        w_state_nxt = ST_PAUSED;
                end
                default:    w_state_nxt = c_RESET_STATE;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_RESET_STATE;
            r_running    <= START_RUNNING;
            r_done       <= 1'b0;
            r_is_adj     <= 1'b0;
            r_is_sel_sec <= 1'b0;
            r_pause_q    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_running    <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_EXPIRED);
            r_is_adj     <= (w_state_nxt == ST_ADJUST);
            r_is_sel_sec <= bus.switch_sel;
            r_pause_q    <= bus.button_pause;
        end
    end

    assign bus.running    = r_running;
    assign bus.done       = r_done;
    assign bus.is_adj     = r_is_adj;
    assign bus.is_sel_sec = r_is_sel_sec;

`ifdef LAP_HOLD_EN
    logic       r_lap_q;
    logic       r_lap_hold;
    logic [3:0] r_snap_min_tens, r_snap_min_ones, r_snap_sec_tens, r_snap_sec_ones;
    logic       w_lap_edge;

    assign w_lap_edge = bus.button_lap && !r_lap_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_q         <= 1'b0;
            r_lap_hold      <= 1'b0;
            r_snap_min_tens <= c_BCD_ZERO;
            r_snap_min_ones <= c_BCD_ZERO;
            r_snap_sec_tens <= c_BCD_ZERO;
            r_snap_sec_ones <= c_BCD_ZERO;
        end else begin
            r_lap_q <= bus.button_lap;
            if (r_state != ST_RUN) begin
                r_lap_hold <= 1'b0;
            end else if (w_lap_edge) begin
                r_lap_hold <= !r_lap_hold;
                if (!r_lap_hold) begin
                    r_snap_min_tens <= w_min_tens;
                    r_snap_min_ones <= w_min_ones;
                    r_snap_sec_tens <= w_sec_tens;
                    r_snap_sec_ones <= w_sec_ones;
                end
            end
        end
    end

    assign bus.bcd_min_tens = r_lap_hold ? r_snap_min_tens : w_min_tens;
    assign bus.bcd_min_ones = r_lap_hold ? r_snap_min_ones : w_min_ones;
    assign bus.bcd_sec_tens = r_lap_hold ? r_snap_sec_tens : w_sec_tens;
    assign bus.bcd_sec_ones = r_lap_hold ? r_snap_sec_ones : w_sec_ones;
`else
    assign bus.bcd_min_tens = w_min_tens;
    assign bus.bcd_min_ones = w_min_ones;
    assign bus.bcd_sec_tens = w_sec_tens;
    assign bus.bcd_sec_ones = w_sec_ones;
`endif

endmodule : bcd_timer_core
`default_nettype wire

// File: tb/tb_bcd_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bcd_timer_core                                            |
// | Description : Directed self-checking bench for bcd_timer_core.             |
// |               u_dut : MAX_MIN=99, START_RUNNING=0                          |
// |               u_dut5: MAX_MIN=5,  START_RUNNING=1                          |
// |               Lap snapshot checks run when LAP_HOLD_EN is defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bcd_timer_core;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bcd_timer_core_if bus ();
    bcd_timer_core_if bus5 ();

    bcd_timer_core #(.MAX_MIN(99), .START_RUNNING(1'b0)) u_dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    bcd_timer_core #(.MAX_MIN(5), .START_RUNNING(1'b1)) u_dut5 (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (bus5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] t_main();
        return {16'h0, bus.bcd_min_tens, bus.bcd_min_ones, bus.bcd_sec_tens, bus.bcd_sec_ones};
    endfunction

    function automatic logic [31:0] t_five();
        return {16'h0, bus5.bcd_min_tens, bus5.bcd_min_ones, bus5.bcd_sec_tens, bus5.bcd_sec_ones};
    endfunction

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_1hz = 1'b1; step(); bus.tick_1hz = 1'b0;
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_2hz = 1'b1; step(); bus.tick_2hz = 1'b0;
        end
    endtask

    task automatic press();
        bus.button_pause = 1'b1; step();
        bus.button_pause = 1'b0; step();
    endtask

    // Enter ADJUST, set minutes then seconds by increments, leave to PAUSED.
    task automatic adjust_by(input int n_min, input int n_sec);
        bus.switch_adj = 1'b1; step();
        bus.switch_sel = 1'b0; tick2(n_min);
        bus.switch_sel = 1'b1; tick2(n_sec);
        bus.switch_adj = 1'b0; step();
    endtask

    task automatic tick2_5(input int n);
        for (int i = 0; i < n; i++) begin
            bus5.tick_2hz = 1'b1; step(); bus5.tick_2hz = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick_1hz = 1'b0;  bus.tick_2hz = 1'b0;  bus.button_pause = 1'b0;
        bus.switch_adj = 1'b0; bus.switch_sel = 1'b0; bus.mode_down = 1'b0;
        bus5.tick_1hz = 1'b0; bus5.tick_2hz = 1'b0; bus5.button_pause = 1'b0;
        bus5.switch_adj = 1'b0; bus5.switch_sel = 1'b0; bus5.mode_down = 1'b0;
`ifdef LAP_HOLD_EN
        bus.button_lap = 1'b0;
        bus5.button_lap = 1'b0;
`endif
        repeat (3) step();

        // Reset state
        check("rst_time",    t_main(),        32'h0000);
        check("rst_running", b(bus.running), 32'd0);
        check("rst_adj",     b(bus.is_adj),  32'd0);
        check("rst_done",    b(bus.done),    32'd0);
        check("rst_sel",     b(bus.is_sel_sec), 32'd0);
        check("rst5_running", b(bus5.running), 32'd1);
        check("rst5_time",   t_five(),        32'h0000);
        rst_n = 1'b1;
        step();

        // Count up across a minute carry
        adjust_by(0, 58);
        check("adj_0058",    t_main(),        32'h0058);
        check("paused_0058", b(bus.running), 32'd0);
        press();
        check("run_after_press", b(bus.running), 32'd1);
        tick1(1);
        check("up_0059",     t_main(),        32'h0059);
        tick1(1);
        check("up_0100",     t_main(),        32'h0100);
        check("up_running",  b(bus.running), 32'd1);

        // Count down with borrow, then expiry
        bus.mode_down = 1'b1;
        tick1(1);
        check("dn_0059",     t_main(),        32'h0059);
        tick1(58);
        check("dn_0001",     t_main(),        32'h0001);
        check("dn_no_done",  b(bus.done),    32'd0);
        tick1(1);
        check("dn_0000",     t_main(),        32'h0000);
        check("dn_done",     b(bus.done),    32'd1);
        check("dn_not_run",  b(bus.running), 32'd0);
        tick1(2);
        check("exp_hold",    t_main(),        32'h0000);
        press();
        check("exp_clr_done", b(bus.done),   32'd0);
        check("exp_paused",  b(bus.running), 32'd0);
        press();
        check("pause_ignored_zero", b(bus.running), 32'd0);
        tick1(1);
        check("paused_hold", t_main(),        32'h0000);

        // Tick at 00:00 in RUN (after mode change) expires without decrementing
        bus.mode_down = 1'b0;
        press();
        check("run_at_zero", b(bus.running), 32'd1);
        bus.mode_down = 1'b1;
        tick1(1);
        check("zero_tick_time", t_main(),     32'h0000);
        check("zero_tick_done", b(bus.done), 32'd1);
        press();
        bus.mode_down = 1'b0;

        // Adjust mode from RUN at 12:34
        adjust_by(12, 34);
        press();
        check("run_1234",    t_main(),        32'h1234);
        check("run_1234_r",  b(bus.running), 32'd1);
        bus.switch_adj = 1'b1; step();
        check("adj_on",      b(bus.is_adj),  32'd1);
        check("adj_not_run", b(bus.running), 32'd0);
        bus.switch_sel = 1'b1;
        tick2(3);
        check("adj_1237",    t_main(),        32'h1237);
        check("adj_sel_sec", b(bus.is_sel_sec), 32'd1);
        bus.switch_sel = 1'b0;
        tick2(87);
        check("adj_9937",    t_main(),        32'h9937);
        tick2(1);
        check("adj_min_wrap", t_main(),       32'h0037);
        check("adj_sel_min", b(bus.is_sel_sec), 32'd0);
        tick1(1);
        check("adj_ign_tick", t_main(),       32'h0037);
        press();
        check("adj_ign_pause", b(bus.is_adj), 32'd1);
        bus.switch_sel = 1'b1;
        tick2(22);
        check("adj_0059",    t_main(),        32'h0059);
        tick2(1);
        check("adj_sec_nocarry", t_main(),    32'h0000);
        tick2(10);
        bus.switch_adj = 1'b0; step();
        check("adj_off",     b(bus.is_adj),  32'd0);
        check("adj_to_pause", b(bus.running), 32'd0);
        press();
        check("run_0010",    t_main(),        32'h0010);

        // Simultaneous tick and pause edge
        bus.tick_1hz = 1'b1; bus.button_pause = 1'b1; step();
        bus.tick_1hz = 1'b0; bus.button_pause = 1'b0; step();
        check("tp_0011",     t_main(),        32'h0011);
        check("tp_paused",   b(bus.running), 32'd0);
        tick1(2);
        check("tp_hold",     t_main(),        32'h0011);

        // Asynchronous reset mid-count
        adjust_by(7, 33);
        press();
        tick1(1);
        check("pre_rst_0745", t_main(),       32'h0745);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_time",   t_main(),        32'h0000);
        check("arst_running", b(bus.running), 32'd0);
        check("arst5_running", b(bus5.running), 32'd1);
        step();
        rst_n = 1'b1;
        step();

`ifdef LAP_HOLD_EN
        // Lap snapshot
        adjust_by(0, 20);
        press();
        bus.button_lap = 1'b1; step(); bus.button_lap = 1'b0; step();
        tick1(5);
        check("lap_hold",    t_main(),        32'h0020);
        bus.button_lap = 1'b1; step(); bus.button_lap = 1'b0; step();
        check("lap_release", t_main(),        32'h0025);
        press();
`endif

        // MAX_MIN = 5 instance: adjust limit and count-up wrap
        bus5.switch_adj = 1'b1; step();
        bus5.switch_sel = 1'b0;
        tick2_5(5);
        check("m5_adj_05",   t_five(),        32'h0500);
        tick2_5(1);
        check("m5_adj_wrap", t_five(),        32'h0000);
        tick2_5(5);
        bus5.switch_sel = 1'b1;
        tick2_5(59);
        check("m5_0559",     t_five(),        32'h0559);
        bus5.switch_adj = 1'b0; step();
        bus5.button_pause = 1'b1; step(); bus5.button_pause = 1'b0; step();
        check("m5_running",  b(bus5.running), 32'd1);
        bus5.tick_1hz = 1'b1; step(); bus5.tick_1hz = 1'b0;
        check("m5_wrap",     t_five(),        32'h0000);
        check("m5_no_done",  b(bus5.done),   32'd0);
        check("m5_still_run", b(bus5.running), 32'd1);
        bus5.tick_1hz = 1'b1; step(); bus5.tick_1hz = 1'b0;
        check("m5_0001",     t_five(),        32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bcd_timer_core
`default_nettype wire
